// File: rtl/sys_array_mm_if.sv
// Handshake and result bus for the sys_array_mm systolic matrix multiplier.
// The bench drives the master side and the array sits on the slave side.
interface sys_array_mm_if #(
  parameter int N    = 4,
  parameter int DW   = 32,
  parameter int KMAX = 16,
  parameter int AW   = 2*DW + $clog2(KMAX),
  parameter int KW   = $clog2(KMAX+1)
);
  logic              start;
  logic [KW-1:0]     k_len;
  logic              in_valid;
  logic              in_ready;
  logic [N*DW-1:0]   a_col;
  logic [N*DW-1:0]   b_row;
  logic              busy;
  logic              done;
  logic [N*N*AW-1:0] c_out;

  modport master (
    output start, k_len, in_valid, a_col, b_row,
    input  in_ready, busy, done, c_out
  );

  modport slave (
    input  start, k_len, in_valid, a_col, b_row,
    output in_ready, busy, done, c_out
  );
endinterface

// File: rtl/sys_array_mm.sv
// NxN output-stationary systolic multiplier C = A*B with internal operand skew and a
// start/busy/done FSM. Define SYS_ARRAY_SIGNED_EN for two's-complement operands.
module sys_array_mm #(
  parameter int N    = 4,
  parameter int DW   = 32,
  parameter int KMAX = 16,
  parameter int AW   = 2*DW + $clog2(KMAX),
  parameter int KW   = $clog2(KMAX+1)
) (
  input logic          clk,
  input logic          rst,
  sys_array_mm_if.slave bus
);

  // One counter serves both slice countdown (LOAD) and drain count (DRAIN).
  localparam int CW = (KW > $clog2(2*N)) ? KW : $clog2(2*N);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE} state_e;

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic            in_ready_q;
  logic            busy_q;
  logic            done_q;
  logic            accept;
  logic            start_clr;
  logic [KW-1:0]   k_clamp;

  function automatic logic [AW-1:0] mac_prod(input logic [DW-1:0] a, input logic [DW-1:0] b);
`ifdef SYS_ARRAY_SIGNED_EN
    logic signed [2*DW-1:0] p;
    p = (2*DW)'($signed(a)) * (2*DW)'($signed(b));
    return {{(AW-2*DW){p[2*DW-1]}}, p};
`else
    logic [2*DW-1:0] p;
    p = (2*DW)'(a) * (2*DW)'(b);
    return {{(AW-2*DW){1'b0}}, p};
`endif
  endfunction

  assign accept    = bus.in_valid & in_ready_q;
  assign start_clr = (state_q == S_IDLE) & bus.start;
  assign k_clamp   = (bus.k_len > KW'(KMAX)) ? KW'(KMAX) : bus.k_len;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            cnt_q <= CW'(k_clamp);
            if (k_clamp == '0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q    <= S_LOAD;
              in_ready_q <= 1'b1;
              busy_q     <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (accept) begin
            if (cnt_q == CW'(1)) begin
              state_q    <= S_DRAIN;
              in_ready_q <= 1'b0;
              cnt_q      <= CW'(1);
            end else begin
              cnt_q <= cnt_q - CW'(1);
            end
          end
        end
        // Last slice needs 2N-1 more edges to reach the far corner PE.
        S_DRAIN: begin
          if (cnt_q == CW'(2*N-1)) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready = in_ready_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

  // Unaccepted cycles inject a zero slice so bubbles add nothing.
  logic [N-1:0][DW-1:0] a_in, b_in;
  logic [N-1:0][DW-1:0] a_feed, b_feed;

  assign a_in = accept ? bus.a_col : '0;
  assign b_in = accept ? bus.b_row : '0;

  for (genvar gi = 0; gi < N; gi++) begin : g_lane
    if (gi == 0) begin : g_direct
      assign a_feed[gi] = a_in[gi];
      assign b_feed[gi] = b_in[gi];
    end else begin : g_skew
      logic [DW-1:0] a_sk_q [gi];
      logic [DW-1:0] b_sk_q [gi];

      always_ff @(posedge clk) begin
        if (!rst) begin
          for (int d = 0; d < gi; d++) begin
            a_sk_q[d] <= '0;
            b_sk_q[d] <= '0;
          end
        end else begin
          a_sk_q[0] <= a_in[gi];
          b_sk_q[0] <= b_in[gi];
          for (int d = 1; d < gi; d++) begin
            a_sk_q[d] <= a_sk_q[d-1];
            b_sk_q[d] <= b_sk_q[d-1];
          end
        end
      end

      assign a_feed[gi] = a_sk_q[gi-1];
      assign b_feed[gi] = b_sk_q[gi-1];
    end
  end

  // PE operand registers: A moves right along a row, B moves down a column.
  logic [DW-1:0] a_q [N][N];
  logic [DW-1:0] b_q [N][N];

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          a_q[i][j] <= '0;
          b_q[i][j] <= '0;
        end
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        a_q[i][0] <= a_feed[i];
        b_q[0][i] <= b_feed[i];
        for (int j = 1; j < N; j++) begin
          a_q[i][j] <= a_q[i][j-1];
          b_q[j][i] <= b_q[j-1][i];
        end
      end
    end
  end

  logic [AW-1:0] acc_q [N][N];
  logic [AW-1:0] acc_d [N][N];

  always_comb begin
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        acc_d[i][j] = start_clr ? '0 : acc_q[i][j] + mac_prod(a_q[i][j], b_q[i][j]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          acc_q[i][j] <= '0;
        end
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          acc_q[i][j] <= acc_d[i][j];
        end
      end
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_row
    for (genvar gj = 0; gj < N; gj++) begin : g_col
      assign bus.c_out[(gi*N+gj)*AW +: AW] = acc_q[gi][gj];
    end
  end

endmodule

// File: tb/tb_sys_array_mm.sv
// Directed bench for sys_array_mm: a matrix model fills a scoreboard queue at each start
// and the entry is popped and compared when done pulses.
module tb_sys_array_mm;
  localparam int N    = 4;
  localparam int DW   = 32;
  localparam int KMAX = 16;
  localparam int AW   = 2*DW + $clog2(KMAX);
  localparam int KW   = $clog2(KMAX+1);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sys_array_mm_if #(.N(N), .DW(DW), .KMAX(KMAX), .AW(AW), .KW(KW)) bus_if ();

  sys_array_mm #(.N(N), .DW(DW), .KMAX(KMAX), .AW(AW), .KW(KW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  int total  = 0;
  int bad    = 0;
  int edge_n = 0;

  logic [DW-1:0]     am [N][KMAX];
  logic [DW-1:0]     bm [KMAX][N];
  logic [N*N*AW-1:0] exp_q [$];

  task automatic tick();
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  task automatic chk(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [AW-1:0] mul_ext(input logic [DW-1:0] a, input logic [DW-1:0] b);
`ifdef SYS_ARRAY_SIGNED_EN
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    return AW'(p);
`else
    logic [63:0] p;
    p = 64'(a) * 64'(b);
    return AW'(p);
`endif
  endfunction

  function automatic logic [N*N*AW-1:0] model(input int keff);
    logic [N*N*AW-1:0] v;
    logic [AW-1:0]     s;
    v = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        s = '0;
        for (int k = 0; k < keff; k++) s = s + mul_ext(am[i][k], bm[k][j]);
        v[(i*N+j)*AW +: AW] = s;
      end
    end
    return v;
  endfunction

  // Pattern codes: 0 zero, 1 ones, 2 identity, 3 all ones bits, 4 random, 5 4r+c+1, 6 2*I, 8 two.
  function automatic logic [DW-1:0] pat(input int m, input int r, input int c);
    case (m)
      1: return DW'(1);
      2: return (r == c) ? DW'(1) : DW'(0);
      3: return '1;
      4: return $urandom();
      5: return DW'(4*r + c + 1);
      6: return (r == c) ? DW'(2) : DW'(0);
      8: return DW'(2);
      default: return '0;
    endcase
  endfunction

  task automatic setmats(input int ma, input int mb);
    for (int i = 0; i < N; i++)
      for (int k = 0; k < KMAX; k++) am[i][k] = pat(ma, i, k);
    for (int k = 0; k < KMAX; k++)
      for (int j = 0; j < N; j++) bm[k][j] = pat(mb, k, j);
  endtask

  function automatic logic [AW-1:0] cel(input int i, input int j);
    return bus_if.c_out[(i*N+j)*AW +: AW];
  endfunction

  task automatic check_c(input string tag, input logic [N*N*AW-1:0] e);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        chk($sformatf("%s_c%0d%0d", tag, i, j), cel(i, j), e[(i*N+j)*AW +: AW]);
  endtask

  task automatic run(input string tag, input int klen, input bit alt, input bit mid_start);
    int keff, nacc, last;
    bit v, r, seen;
    logic [N*N*AW-1:0] e;
    keff = (klen > KMAX) ? KMAX : klen;
    exp_q.push_back(model(keff));
    bus_if.start    = 1'b1;
    bus_if.k_len    = KW'(klen);
    bus_if.in_valid = 1'b0;
    tick();
    bus_if.start = 1'b0;
    if (keff == 0) begin
      chk({tag, "_done"}, AW'(bus_if.done), AW'(1));
      chk({tag, "_rdy"}, AW'(bus_if.in_ready), AW'(0));
      chk({tag, "_busy"}, AW'(bus_if.busy), AW'(0));
      e = exp_q.pop_front();
      check_c(tag, e);
      tick();
      chk({tag, "_done_end"}, AW'(bus_if.done), AW'(0));
      chk({tag, "_rdy_end"}, AW'(bus_if.in_ready), AW'(0));
      return;
    end
    chk({tag, "_busy_load"}, AW'(bus_if.busy), AW'(1));
    nacc = 0;
    last = edge_n;
    seen = 1'b0;
    for (int cyc = 0; cyc < 200 && !seen; cyc++) begin
      v = alt ? (cyc % 2 == 0) : 1'b1;
      bus_if.in_valid = v;
      for (int i = 0; i < N; i++) begin
        if (nacc < keff) begin
          bus_if.a_col[i*DW +: DW] = am[i][nacc];
          bus_if.b_row[i*DW +: DW] = bm[nacc][i];
        end else begin
          bus_if.a_col[i*DW +: DW] = $urandom();
          bus_if.b_row[i*DW +: DW] = $urandom();
        end
      end
      if (mid_start) begin
        bus_if.start = (cyc == 1);
        bus_if.k_len = (cyc == 1) ? KW'(1) : KW'(klen);
      end
      r = bus_if.in_ready;
      tick();
      if (v && r) begin
        nacc++;
        last = edge_n;
      end
      seen = bus_if.done;
    end
    bus_if.in_valid = 1'b0;
    bus_if.start    = 1'b0;
    chk({tag, "_done_seen"}, AW'(seen), AW'(1));
    chk({tag, "_accepts"}, AW'(nacc), AW'(keff));
    chk({tag, "_latency"}, AW'(edge_n - last), AW'(2*N-1));
    chk({tag, "_busy_at_done"}, AW'(bus_if.busy), AW'(0));
    e = exp_q.pop_front();
    check_c(tag, e);
    tick();
    chk({tag, "_done_pulse"}, AW'(bus_if.done), AW'(0));
    check_c({tag, "_hold"}, e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] m2;
    rst             = 1'b0;
    bus_if.start    = 1'b0;
    bus_if.k_len    = '0;
    bus_if.in_valid = 1'b0;
    bus_if.a_col    = '0;
    bus_if.b_row    = '0;
    repeat (3) tick();
    chk("rst_rdy", AW'(bus_if.in_ready), AW'(0));
    chk("rst_busy", AW'(bus_if.busy), AW'(0));
    chk("rst_done", AW'(bus_if.done), AW'(0));
    check_c("rst", '0);
    rst = 1'b1;
    tick();

    // identity A passes B straight through
    setmats(2, 5);
    run("t1", 4, 1'b0, 1'b0);
    chk("t1_c12", cel(1, 2), AW'(7));
    chk("t1_c33", cel(3, 3), AW'(16));

    setmats(1, 1);
    run("t2", 4, 1'b1, 1'b0);
    chk("t2_c21", cel(2, 1), AW'(4));

    setmats(3, 3);
    run("t3", 16, 1'b0, 1'b0);
`ifndef SYS_ARRAY_SIGNED_EN
    chk("t3_c33", cel(3, 3), 68'hFFFFFFFE000000010);
`endif

    setmats(1, 1);
    run("t4a", 4, 1'b0, 1'b1);
    chk("t4a_c00", cel(0, 0), AW'(4));
    setmats(2, 6);
    run("t4b", 4, 1'b0, 1'b0);
    chk("t4b_c00", cel(0, 0), AW'(2));
    chk("t4b_c01", cel(0, 1), AW'(0));

    setmats(4, 4);
    run("t5a", 0, 1'b0, 1'b0);
    run("t5b", 20, 1'b0, 1'b0);

    // reset lands after two of four slices
    setmats(1, 1);
    bus_if.start = 1'b1;
    bus_if.k_len = KW'(4);
    tick();
    bus_if.start    = 1'b0;
    bus_if.in_valid = 1'b1;
    for (int i = 0; i < N; i++) begin
      bus_if.a_col[i*DW +: DW] = DW'(1);
      bus_if.b_row[i*DW +: DW] = DW'(1);
    end
    tick();
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("t6_rdy", AW'(bus_if.in_ready), AW'(0));
    chk("t6_busy", AW'(bus_if.busy), AW'(0));
    chk("t6_done", AW'(bus_if.done), AW'(0));
    check_c("t6_rst", '0);
    bus_if.in_valid = 1'b0;
    repeat (8) tick();
    check_c("t6_flush", '0);
    setmats(4, 4);
    run("t6", 4, 1'b1, 1'b0);

`ifdef SYS_ARRAY_SIGNED_EN
    setmats(3, 8);
    run("ts", 1, 1'b0, 1'b0);
    m2    = '1;
    m2[0] = 1'b0;
    chk("ts_c00", cel(0, 0), m2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
